// File: rtl/reg_file_2r1w.sv
// ProtoCore general-purpose register file: 2**ADDR_WIDTH entries, two
// asynchronous read ports and one synchronous write port, no write-to-read bypass.
module reg_file_2r1w #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] ra,
  input  logic [ADDR_WIDTH-1:0] rb,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] read_a,
  output logic [DATA_WIDTH-1:0] read_b
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];

  // Reset clears every entry and wins over a write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  // Reads see the stored contents only; a same-cycle write shows after the edge.
  assign read_a = regs[ra];
  assign read_b = regs[rb];

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w: reference array model, expected
// read values queued when addresses are driven and compared as outputs settle.
module tb_reg_file_2r1w;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] ra, rb, wa;
  logic [DW-1:0] wd;
  logic          we;
  logic [DW-1:0] read_a, read_b;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_v;

  int checks;
  int failures;

  reg_file_2r1w #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ra     (ra),
    .rb     (rb),
    .wa     (wa),
    .wd     (wd),
    .we     (we),
    .read_a (read_a),
    .read_b (read_b)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  // Driver tasks: inputs change on the falling edge, model updated after the rising edge.
  task automatic drive_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic en);
    @(negedge clk);
    wa = a; wd = d; we = en;
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
    end else if (en) begin
      model[a] = d;
    end
    #1;
  endtask

  task automatic drive_reset_edge(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    rst_n = 1'b0; we = 1'b1; wa = a; wd = d;
    @(posedge clk);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    #1;
    @(negedge clk);
    rst_n = 1'b1; we = 1'b0;
  endtask

  task automatic test_reset();
    drive_reset_edge(4'd2, 8'h55);
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h00);
      ra = AW'(i); rb = AW'(DEPTH - 1 - i);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (read_a !== exp_v) begin
        $display("FAIL reset_a[%0d]: got %h expected %h", i, read_a, exp_v);
        failures++;
      end
      exp_v = exp_q.pop_front();
      checks++;
      if (read_b !== exp_v) begin
        $display("FAIL reset_b[%0d]: got %h expected %h", DEPTH - 1 - i, read_b, exp_v);
        failures++;
      end
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) drive_write(AW'(i), DW'(i * 8'h11), 1'b1);
    @(negedge clk);
    we = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(DW'(i * 8'h11));
      exp_q.push_back(DW'((DEPTH - 1 - i) * 8'h11));
      ra = AW'(i); rb = AW'(DEPTH - 1 - i);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (read_a !== exp_v) begin
        $display("FAIL fill_a[%0d]: got %h expected %h", i, read_a, exp_v);
        failures++;
      end
      exp_v = exp_q.pop_front();
      checks++;
      if (read_b !== exp_v) begin
        $display("FAIL fill_b[%0d]: got %h expected %h", DEPTH - 1 - i, read_b, exp_v);
        failures++;
      end
    end
  endtask

  task automatic test_overwrite();
    drive_write(4'd3, 8'hAA, 1'b1);
    @(negedge clk);
    we = 1'b0;
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'hAA);
    ra = 4'd3; rb = 4'd3;
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (read_a !== exp_v) begin
      $display("FAIL overwrite_a: got %h expected %h", read_a, exp_v);
      failures++;
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (read_b !== exp_v) begin
      $display("FAIL overwrite_b: got %h expected %h", read_b, exp_v);
      failures++;
    end
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back((i == 3) ? 8'hAA : DW'(i * 8'h11));
      ra = AW'(i);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (read_a !== exp_v) begin
        $display("FAIL overwrite_others[%0d]: got %h expected %h", i, read_a, exp_v);
        failures++;
      end
    end
  endtask

  task automatic test_we_low();
    drive_write(4'd5, 8'h11, 1'b0);
    exp_q.push_back(8'h55);
    ra = 4'd5;
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (read_a !== exp_v) begin
      $display("FAIL we_low: got %h expected %h", read_a, exp_v);
      failures++;
    end
  endtask

  task automatic test_no_bypass();
    @(negedge clk);
    ra = 4'd7; rb = 4'd7; we = 1'b1; wa = 4'd7; wd = 8'h3C;
    exp_q.push_back(8'h77);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (read_a !== exp_v) begin
      $display("FAIL no_bypass_before: got %h expected %h", read_a, exp_v);
      failures++;
    end
    @(posedge clk);
    model[7] = 8'h3C;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h3C);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (read_a !== exp_v) begin
      $display("FAIL no_bypass_after_a: got %h expected %h", read_a, exp_v);
      failures++;
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (read_b !== exp_v) begin
      $display("FAIL no_bypass_after_b: got %h expected %h", read_b, exp_v);
      failures++;
    end
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          en;
    for (int n = 0; n < 200; n++) begin
      a  = AW'($urandom_range(0, DEPTH - 1));
      d  = DW'($urandom_range(0, 255));
      en = ($urandom_range(0, 3) != 0);
      drive_write(a, d, en);
      ra = AW'($urandom_range(0, DEPTH - 1));
      rb = (n % 4 == 0) ? a : AW'($urandom_range(0, DEPTH - 1));
      exp_q.push_back(model[ra]);
      exp_q.push_back(model[rb]);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (read_a !== exp_v) begin
        $display("FAIL random_a[n=%0d ra=%0d]: got %h expected %h", n, ra, read_a, exp_v);
        failures++;
      end
      exp_v = exp_q.pop_front();
      checks++;
      if (read_b !== exp_v) begin
        $display("FAIL random_b[n=%0d rb=%0d]: got %h expected %h", n, rb, read_b, exp_v);
        failures++;
      end
    end
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic test_reset_mid();
    drive_write(4'd9, 8'h99, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      if (i != 9) drive_write(AW'(i), DW'(8'hC0 | i), 1'b1);
    end
    @(negedge clk);
    rst_n = 1'b0; we = 1'b1; wa = 4'd9; wd = 8'hEE; ra = 4'd9;
    exp_q.push_back(8'h99);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (read_a !== exp_v) begin
      $display("FAIL reset_mid_before_edge: got %h expected %h", read_a, exp_v);
      failures++;
    end
    @(posedge clk);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    #1;
    @(negedge clk);
    rst_n = 1'b1; we = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(model[i]);
      exp_q.push_back(8'h00);
      ra = AW'(i); rb = AW'(i);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (read_a !== exp_v) begin
        $display("FAIL reset_mid_a[%0d]: got %h expected %h", i, read_a, exp_v);
        failures++;
      end
      exp_v = exp_q.pop_front();
      checks++;
      if (read_b !== exp_v) begin
        $display("FAIL reset_mid_b[%0d]: got %h expected %h", i, read_b, exp_v);
        failures++;
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b1; we = 1'b0; wa = '0; wd = '0; ra = '0; rb = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = 'x;
    repeat (2) @(posedge clk);
    test_reset();
    test_fill();
    test_overwrite();
    test_we_low();
    test_no_bypass();
    test_random();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
      failures++;
    end
    checks++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- General-purpose register file for the ProtoCore datapath: 16 entries of 8 bits.
- Two independent asynchronous read ports (operands A and B) and one synchronous write port.
- Sits between decode (register addresses) and ALU (operand values) / writeback (result data).

Parameters:
- DATA_WIDTH, 8, width of each register and of the wd/read_a/read_b buses.
- ADDR_WIDTH, 4, address width; depth = 2**ADDR_WIDTH (16 entries).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- ra  input  ADDR_WIDTH  read port A address.
- rb  input  ADDR_WIDTH  read port B address.
- wa  input  ADDR_WIDTH  write address.
- wd  input  DATA_WIDTH  write data.
- we  input  1  write enable, active high.
- read_a  output  DATA_WIDTH  contents of register[ra].
- read_b  output  DATA_WIDTH  contents of register[rb].

Behaviour:
- Storage: 2**ADDR_WIDTH registers of DATA_WIDTH bits each.
- All entries, including entry 0, are ordinary writable registers; there is no hardwired-zero register.
- Reset:
  - On a rising clk edge with rst_n=0, every register is cleared to 0.
  - Reset has priority over a simultaneous write; a write presented during reset is dropped.
  - Reset is synchronous only: asserting rst_n between edges changes nothing until the next edge.
  - Consequently read_a and read_b read 0x00 for every address after the reset edge.
- Write:
  - On a rising clk edge with rst_n=1 and we=1, register[wa] <= wd.
  - Exactly one entry changes per cycle.
  - With we=0 no register changes, whatever the values of wa and wd.
- Read:
  - Purely combinational: read_a = register[ra], read_b = register[rb].
  - Zero-cycle latency from an address change.
  - Ports are fully independent; ra==rb is legal and both outputs show the same value.
- Read/write collision (ra or rb == wa with we=1):
  - No bypass. Before the edge, the output shows the old contents.
  - The new value appears immediately after the rising edge that performs the write.
- Uninitialised state: simulation without a reset may show X; implementations must not rely on power-up values.
- No other outputs and no internal pipeline.

Test Plan:
- Reset: hold rst_n=0 for 1 edge with we=1, wa=2, wd=0x55, then release -> read_a/read_b = 0x00 for all 16 addresses, including reg2.
- Fill: for i=0..15, we=1, wa=i, wd=i*0x11, one edge each. Then we=0 and sweep ra=i, rb=15-i -> read_a=i*0x11 and read_b=(15-i)*0x11 (e.g. ra=0 gives 0x00, rb=15 gives 0xFF).
- Overwrite: after the fill, we=1, wa=3, wd=0xAA, one edge, then ra=rb=3 -> read_a=read_b=0xAA; all other entries unchanged (reg4=0x44).
- Write-enable low: we=0, wa=5, wd=0x11, one edge, then ra=5 -> read_a=0x55 (unchanged).
- No bypass: ra=7 (holding 0x77), we=1, wa=7, wd=0x3C. Before the edge read_a=0x77; immediately after the edge read_a=0x3C.
- Reset mid-operation: with reg9=0x99, drive rst_n=0 and we=1, wa=9, wd=0xEE for one edge -> reg9=0x00 and every other register=0x00.
